// File: rtl/count_sequencer_if.sv
// Requester-side bundle for count_sequencer: two level requests with run lengths,
// a shared count enable, and the registered grant/done/count/busy results.
interface count_sequencer_if #(
    parameter int WIDTH = 4
);
    // Handshake: reqN is a level held by the requester until doneN pulses or it
    // chooses to abort by dropping it; lenN is sampled only on the granting edge;
    // gntN stays high from grant through the done cycle; doneN is a one-cycle pulse.
    logic             req0;
    logic [WIDTH-1:0] len0;
    logic             req1;
    logic [WIDTH-1:0] len1;
    logic             en;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic [1:0]       state_dbg;

    modport master (
        output req0, len0, req1, len1, en,
        input  gnt0, gnt1, done0, done1, count, busy, state_dbg
    );

    modport slave (
        input  req0, len0, req1, len1, en,
        output gnt0, gnt1, done0, done1, count, busy, state_dbg
    );
endinterface

// File: rtl/count_sequencer.sv
// Two-requester round-robin sequencer that runs a shared counter for the winner's
// latched length, then pulses done; all outputs come straight from flops.
module count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    count_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;

    logic             win;
    logic             owner_req;
    logic [WIDTH-1:0] term;

    // len=0 wraps to all-ones, giving a full 2^WIDTH-cycle run.
    assign term      = len_q - {{(WIDTH-1){1'b0}}, 1'b1};
    assign owner_req = owner_q ? bus.req1 : bus.req0;

    always_comb begin
        state_d = state_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        count_d = count_q;
        len_d   = len_q;
        last_d  = last_q;
        owner_d = owner_q;
        win     = 1'b0;

        case (state_q)
            IDLE: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                count_d = '0;
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester not served last wins.
                    win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    owner_d = win;
                    state_d = RUN;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    len_d   = win ? bus.len1 : bus.len0;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    count_d = '0;
                    last_d  = owner_q;
                end else if (bus.en) begin
                    if (count_q == term) begin
                        state_d = DONE;
                        done0_d = ~owner_q;
                        done1_d = owner_q;
                        last_d  = owner_q;
                    end else begin
                        count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            count_q <= count_d;
            len_q   <= len_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.count     = count_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: basic run, tie, wrap, pause, abort and
// mid-run reset, each step compared against hand-computed output vectors.
module tb_count_sequencer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    count_sequencer_if #(.WIDTH(4)) bus ();

    count_sequencer #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Output vector: {gnt0, gnt1, done0, done1, busy, count[3:0]}
    function automatic logic [31:0] vec(input logic g0, input logic g1, input logic d0,
                                        input logic d1, input logic b, input int c);
        logic [3:0] c4;
        c4 = c[3:0];
        return {23'd0, g0, g1, d0, d1, b, c4};
    endfunction

    function automatic logic [31:0] obs();
        return {23'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.count};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.len0 = 4'd0;
        bus.len1 = 4'd0;
        bus.en   = 1'b0;
        step();
        step();
        check("reset_outputs", obs(), vec(0, 0, 0, 0, 0, 0));
        check("reset_state", {30'd0, bus.state_dbg}, 32'd0);
        reset = 1'b0;

        // Basic run, len0 changed after grant must not matter
        bus.req0 = 1'b1; bus.len0 = 4'd3; bus.en = 1'b1;
        step(); check("basic_grant", obs(), vec(1, 0, 0, 0, 1, 0));
        bus.len0 = 4'd9;
        step(); check("basic_c1", obs(), vec(1, 0, 0, 0, 1, 1));
        step(); check("basic_c2", obs(), vec(1, 0, 0, 0, 1, 2));
        step(); check("basic_done", obs(), vec(1, 0, 1, 0, 1, 2));
        bus.req0 = 1'b0;
        step(); check("basic_idle", obs(), vec(0, 0, 0, 0, 0, 0));

        // Tie from reset: requester 0 first, one idle cycle, then requester 1
        reset = 1'b1; step(); reset = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.len0 = 4'd2; bus.len1 = 4'd2;
        step(); check("tie_gnt0", obs(), vec(1, 0, 0, 0, 1, 0));
        step(); check("tie_r0_c1", obs(), vec(1, 0, 0, 0, 1, 1));
        step(); check("tie_done0", obs(), vec(1, 0, 1, 0, 1, 1));
        bus.req0 = 1'b0;
        step(); check("tie_gap", obs(), vec(0, 0, 0, 0, 0, 0));
        step(); check("tie_gnt1", obs(), vec(0, 1, 0, 0, 1, 0));
        step(); check("tie_r1_c1", obs(), vec(0, 1, 0, 0, 1, 1));
        step(); check("tie_done1", obs(), vec(0, 1, 0, 1, 1, 1));
        bus.req1 = 1'b0;
        step(); check("tie_idle", obs(), vec(0, 0, 0, 0, 0, 0));

        // Wrap: len1=0 runs 16 enabled cycles
        bus.req1 = 1'b1; bus.len1 = 4'd0;
        step(); check("wrap_grant", obs(), vec(0, 1, 0, 0, 1, 0));
        for (int i = 1; i < 16; i++) begin
            step(); check($sformatf("wrap_c%0d", i), obs(), vec(0, 1, 0, 0, 1, i));
        end
        step(); check("wrap_done", obs(), vec(0, 1, 0, 1, 1, 15));
        bus.req1 = 1'b0;
        step(); check("wrap_idle", obs(), vec(0, 0, 0, 0, 0, 0));

        // Pause: en low for two cycles at count 1
        bus.req0 = 1'b1; bus.len0 = 4'd4;
        step(); check("pause_grant", obs(), vec(1, 0, 0, 0, 1, 0));
        step(); check("pause_c1", obs(), vec(1, 0, 0, 0, 1, 1));
        bus.en = 1'b0;
        step(); check("pause_hold1", obs(), vec(1, 0, 0, 0, 1, 1));
        step(); check("pause_hold2", obs(), vec(1, 0, 0, 0, 1, 1));
        bus.en = 1'b1;
        step(); check("pause_c2", obs(), vec(1, 0, 0, 0, 1, 2));
        step(); check("pause_c3", obs(), vec(1, 0, 0, 0, 1, 3));
        step(); check("pause_done", obs(), vec(1, 0, 1, 0, 1, 3));
        bus.req0 = 1'b0;
        step(); check("pause_idle", obs(), vec(0, 0, 0, 0, 0, 0));

        // Abort: req0 dropped at count 3
        bus.req0 = 1'b1; bus.len0 = 4'd8;
        step(); check("abort_grant", obs(), vec(1, 0, 0, 0, 1, 0));
        step(); step(); step();
        check("abort_c3", obs(), vec(1, 0, 0, 0, 1, 3));
        bus.req0 = 1'b0;
        step(); check("abort_idle", obs(), vec(0, 0, 0, 0, 0, 0));
        step(); check("abort_no_done", obs(), vec(0, 0, 0, 0, 0, 0));

        // Abort served requester 0, so the next tie goes to requester 1
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.len1 = 4'd8;
        step(); check("rr_after_abort", obs(), vec(0, 1, 0, 0, 1, 0));
        for (int i = 1; i <= 5; i++) step();
        check("midrun_c5", obs(), vec(0, 1, 0, 0, 1, 5));

        // Reset mid-run with requests still high, then pointer back to 1
        reset = 1'b1;
        step(); check("midrun_reset", obs(), vec(0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        step(); check("post_reset_tie", obs(), vec(1, 0, 0, 0, 1, 0));
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step(); check("final_idle", obs(), vec(0, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Parameter WIDTH, default 4, SHALL set the bit width of the shared counter and of the length inputs.
REQ-003 Port clk, input, 1, SHALL be the rising-edge clock for all state.
REQ-004 Port reset, input, 1, SHALL be the synchronous active-high reset.
REQ-005 Port req0, input, 1, SHALL be requester 0's level request, held until done0 or abort.
REQ-006 Port len0, input, WIDTH, SHALL be requester 0's run length, sampled only at grant.
REQ-007 Port req1, input, 1, SHALL be requester 1's level request, held until done1 or abort.
REQ-008 Port len1, input, WIDTH, SHALL be requester 1's run length, sampled only at grant.
REQ-009 Port en, input, 1, SHALL be the count enable (toggle enable): 1 advances the count, 0 holds it.
REQ-010 Port gnt0, output, 1, SHALL be the registered grant to requester 0.
REQ-011 Port gnt1, output, 1, SHALL be the registered grant to requester 1.
REQ-012 Port done0, output, 1, SHALL be a one-cycle completion pulse to requester 0.
REQ-013 Port done1, output, 1, SHALL be a one-cycle completion pulse to requester 1.
REQ-014 Port count, output, WIDTH, SHALL be the registered value of the shared counter.
REQ-015 Port busy, output, 1, SHALL be 1 whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 In IDLE with at least one req high, the block SHALL go to RUN on the next edge.
- It SHALL assert the winner's gnt and load count=0 on that same edge.
- It SHALL latch the winner's len into an internal register at that edge.
REQ-018 Arbitration SHALL be round-robin.
- When both requests are high in IDLE, the requester not served last SHALL win.
- The last-served pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-019 In RUN with en=1, count SHALL increment by 1 per cycle. In RUN with en=0, count and state SHALL hold.
REQ-020 The terminal value SHALL be (latched_len - 1) mod 2^WIDTH.
- len=0 therefore runs 2^WIDTH enabled cycles (count 0..15 for WIDTH=4).
- len=1 runs a single enabled cycle.
REQ-021 In RUN with en=1 and count equal to the terminal value, the next state SHALL be DONE.
- count SHALL hold at the terminal value in DONE.
REQ-022 In DONE, the granted requester's done output SHALL be 1 for exactly one cycle and its gnt SHALL remain 1.
- The next state SHALL be IDLE, with gnt=0 and count=0.
REQ-023 On the RUN-to-DONE edge, the last-served pointer SHALL update to the granted requester.
REQ-024 If the granted requester's req is low in RUN (sampled at an edge), the block SHALL abort.
- Next state IDLE, gnt=0, count=0.
- No done pulse; the last-served pointer SHALL still update.
REQ-025 Requests arriving during RUN or DONE SHALL be ignored until IDLE.
- The earliest new grant SHALL come one cycle after DONE (one IDLE cycle between runs).
REQ-026 changes on len0/len1 after grant SHALL have no effect on the current run.
REQ-027 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle.
REQ-028 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-029 reset=1 at a rising edge SHALL, in every state including mid-RUN, force:
- state IDLE;
- gnt0=gnt1=0 and done0=done1=0;
- count=0 and busy=0;
- last-served pointer=1.
REQ-030 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-031 Basic run: reset, then req0=1, len0=3, en=1 -> gnt0=1 one cycle later; count 0,1,2; then done0=1 for one cycle; then gnt0=0 and count=0.
REQ-032 Tie: req0=req1=1 with len 2 each from reset -> requester 0 served first with done0, one IDLE cycle, then requester 1 granted with done1.
REQ-033 Wrap: req1=1, len1=0, en=1 -> count 0..15 over 16 cycles, then done1 one cycle later.
REQ-034 Pause: len0=4, en=0 for 2 cycles at count=1 -> count holds at 1; done0 arrives 2 cycles later than the unpaused run.
REQ-035 Abort: len0=8, req0 dropped at count=3 -> next cycle IDLE, gnt0=0, count=0, done0 never asserted.
REQ-036 Reset mid-run: reset=1 at count=5 -> next cycle all outputs 0; a subsequent tie grants requester 0.
